acq_accum_buf: RTL and testbench

//   Downstream stage of signal_acq. Takes its 12-bit echo samples (one-cycle

---
 rtl/acq_pkg.sv | 29 ++
 rtl/acq_accum_buf_if.sv | 25 ++
 rtl/acq_accum_ram.sv | 36 +++
 rtl/acq_accum_buf.sv | 171 +++++++++++++++++
 tb/tb_acq_accum_buf.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/acq_pkg.sv
// Shared widths, state encoding and latch-time helpers for the echo co-add buffer.
package acq_pkg;

    localparam int DATA_W = 12;
    localparam int SUM_W  = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [15:0] acqnum);
        if (acqnum > 16'(DEPTH)) begin
            clamp_len = CNT_W'(DEPTH);
        end else begin
            clamp_len = acqnum[CNT_W-1:0];
        end
    endfunction

    function automatic logic [3:0] eff_passes(input logic [3:0] periodnum);
        eff_passes = (periodnum == 4'd0) ? 4'd1 : periodnum;
    endfunction

endpackage

// File: rtl/acq_accum_buf_if.sv
// Sample input, control and DSP readout signals of the co-add buffer.
interface acq_accum_buf_if;
    import acq_pkg::*;

    logic              acq_start;
    logic [15:0]       acqnum;
    logic [3:0]        s_periodnum;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              rd_en;
    logic [SUM_W-1:0]  rd_data;
    logic              rd_valid;
    logic              busy;
    logic              acc_done;

    modport master (
        output acq_start, acqnum, s_periodnum, sample_valid, sample_data, rd_en,
        input  rd_data, rd_valid, busy, acc_done
    );

    modport slave (
        input  acq_start, acqnum, s_periodnum, sample_valid, sample_data, rd_en,
        output rd_data, rd_valid, busy, acc_done
    );
endinterface

// File: rtl/acq_accum_ram.sv
// Sum RAM: one synchronous write port, one synchronous read port (old data on collision).
module acq_accum_ram
    import acq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SUM_W-1:0]  wdata,
    input  logic              re,
    input  logic              sel_rd,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SUM_W-1:0]  q
);
    logic [SUM_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] raddr_s;

    assign raddr_s = sel_rd ? rd_addr : acc_addr;

    // Array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {SUM_W{1'b0}};
        end else if (re) begin
            q <= mem[raddr_s];
        end
    end
endmodule

// File: rtl/acq_accum_buf.sv
// Co-adds strobed echo samples over several passes into a sum RAM, then serves
// the record through a strobed, auto-incrementing read port.
module acq_accum_buf
    import acq_pkg::*;
(
    input  logic           clk_sys,
    input  logic           s_reset,
    acq_accum_buf_if.slave bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, last_idx_s, start_n_s;
    logic [3:0]        p_q, p_d, pass_q, pass_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_ptr_q, rd_ptr_d, wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d, first_q, first_d, fwd_q, fwd_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [SUM_W-1:0]  last_wdata_q, last_wdata_d, rd_data_q, rd_data_d;
    logic [SUM_W-1:0]  ram_q, wdata_s, operand_s, smp_ext_s;
    logic              rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;
    logic              ram_we_s, ram_re_s, ram_sel_rd_s;

    acq_accum_ram u_ram (
        .clk      (clk_sys),
        .rst_n    (s_reset),
        .we       (ram_we_s),
        .waddr    (wr_addr_q),
        .wdata    (wdata_s),
        .re       (ram_re_s),
        .sel_rd   (ram_sel_rd_s),
        .acc_addr (addr_q),
        .rd_addr  (rd_ptr_q),
        .q        (ram_q)
    );

    // Write-back stage; for N==1 the just-written sum is forwarded past the RAM.
    always_comb begin
        smp_ext_s = {{(SUM_W-DATA_W){1'b0}}, smp_q};
        operand_s = fwd_q ? last_wdata_q : ram_q;
        if (first_q) begin
            wdata_s = smp_ext_s;
        end else begin
            wdata_s = operand_s + smp_ext_s;
        end
        ram_we_s = wr_en_q & ~bus.acq_start;
        if (ram_we_s) begin
            last_wdata_d = wdata_s;
        end else begin
            last_wdata_d = last_wdata_q;
        end
        rd_data_d = rd_valid_q ? ram_q : rd_data_q;
    end

    // Sequencing: acq_start restarts from any state and drops the pending write.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        p_d          = p_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        rd_ptr_d     = rd_ptr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        smp_d        = smp_q;
        first_d      = first_q;
        fwd_d        = 1'b0;
        rd_valid_d   = 1'b0;
        ram_re_s     = 1'b0;
        ram_sel_rd_s = 1'b0;
        last_idx_s   = n_q - CNT_W'(1);
        start_n_s    = clamp_len(bus.acqnum);
        if (bus.acq_start) begin
            n_d      = start_n_s;
            p_d      = eff_passes(bus.s_periodnum);
            addr_d   = {ADDR_W{1'b0}};
            pass_d   = 4'd0;
            rd_ptr_d = {ADDR_W{1'b0}};
            state_d  = (start_n_s == {CNT_W{1'b0}}) ? ST_DONE : ST_ACQ;
        end else begin
            case (state_q)
                ST_ACQ: begin
                    if (bus.sample_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        smp_d     = bus.sample_data;
                        first_d   = (pass_q == 4'd0);
                        ram_re_s  = (pass_q != 4'd0);
                        fwd_d     = (pass_q != 4'd0) && wr_en_q && (wr_addr_q == addr_q);
                        if ({1'b0, addr_q} == last_idx_s) begin
                            addr_d = {ADDR_W{1'b0}};
                            if (pass_q == p_q - 4'd1) begin
                                state_d = ST_FLUSH;
                            end else begin
                                pass_d = pass_q + 4'd1;
                            end
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_d  = ST_DONE;
                    rd_ptr_d = {ADDR_W{1'b0}};
                end
                ST_DONE: begin
                    if (bus.rd_en) begin
                        ram_re_s     = 1'b1;
                        ram_sel_rd_s = 1'b1;
                        rd_valid_d   = 1'b1;
                        if ({1'b0, rd_ptr_q} == last_idx_s) begin
                            rd_ptr_d = {ADDR_W{1'b0}};
                        end else begin
                            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_ACQ) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, write pipeline and registered status outputs.
    always_ff @(posedge clk_sys or negedge s_reset) begin
        if (!s_reset) begin
            state_q      <= ST_IDLE;
            n_q          <= {CNT_W{1'b0}};
            p_q          <= 4'd0;
            addr_q       <= {ADDR_W{1'b0}};
            pass_q       <= 4'd0;
            rd_ptr_q     <= {ADDR_W{1'b0}};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            smp_q        <= {DATA_W{1'b0}};
            first_q      <= 1'b0;
            fwd_q        <= 1'b0;
            last_wdata_q <= {SUM_W{1'b0}};
            rd_data_q    <= {SUM_W{1'b0}};
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            p_q          <= p_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            smp_q        <= smp_d;
            first_q      <= first_d;
            fwd_q        <= fwd_d;
            last_wdata_q <= last_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.rd_data  = rd_data_d;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.acc_done = done_q;
endmodule

// File: tb/tb_acq_accum_buf.sv
// Directed and randomized co-add runs checked against a pass/sample-level sum model.
module tb_acq_accum_buf;
    import acq_pkg::*;

    logic clk_sys = 1'b0;
    logic s_reset = 1'b0;

    acq_accum_buf_if bus ();

    acq_accum_buf dut (
        .clk_sys (clk_sys),
        .s_reset (s_reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int mdl_sum [1024];
    int mdl_n, mdl_p, mdl_idx, mdl_pass, mdl_rd;
    bit mdl_active;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int acqnum, input int pn);
        bus.acq_start   = 1'b1;
        bus.acqnum      = 16'(acqnum);
        bus.s_periodnum = 4'(pn);
        tick();
        bus.acq_start   = 1'b0;
        mdl_n      = (acqnum > 1024) ? 1024 : acqnum;
        mdl_p      = (pn == 0) ? 1 : pn;
        mdl_idx    = 0;
        mdl_pass   = 0;
        mdl_rd     = 0;
        mdl_active = (mdl_n > 0);
    endtask

    task automatic push(input int s);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 12'(s);
        tick();
        bus.sample_valid = 1'b0;
        if (mdl_active) begin
            if (mdl_pass == 0) mdl_sum[mdl_idx] = s;
            else mdl_sum[mdl_idx] = mdl_sum[mdl_idx] + s;
            mdl_idx++;
            if (mdl_idx == mdl_n) begin
                mdl_idx = 0;
                mdl_pass++;
                if (mdl_pass == mdl_p) mdl_active = 1'b0;
            end
        end
    endtask

    task automatic read_chk(input string tag);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rd_data), 32'(mdl_sum[mdl_rd]));
        if (mdl_n == 0) mdl_rd++;
        else mdl_rd = (mdl_rd + 1) % mdl_n;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while (!bus.acc_done && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 32'(bus.acc_done), 32'd1);
    endtask

    initial begin
        bus.acq_start    = 1'b0;
        bus.acqnum       = 16'd0;
        bus.s_periodnum  = 4'd0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 12'd0;
        bus.rd_en        = 1'b0;
        mdl_active       = 1'b0;
        mdl_n            = 0;
        #1;
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.acc_done), 32'd0);
        tick();
        tick();
        s_reset = 1'b1;
        tick();

        // 1: single pass, readout with wrap and hold
        start_run(4, 1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 4; i++) push(i);
        wait_done("t1_done", 10);
        for (int i = 0; i < 4; i++) read_chk("t1_rd");
        tick();
        chk("t1_idle_valid", 32'(bus.rd_valid), 32'd0);
        chk("t1_hold_data", 32'(bus.rd_data), 32'd4);
        read_chk("t1_wrap");

        // 2: three passes back-to-back, busy/acc_done handover
        start_run(8, 3);
        for (int i = 0; i < 24; i++) push(12'hFFF);
        chk("t2_flush_busy", 32'(bus.busy), 32'd1);
        chk("t2_flush_done", 32'(bus.acc_done), 32'd0);
        tick();
        chk("t2_busy_fall", 32'(bus.busy), 32'd0);
        chk("t2_done_rise", 32'(bus.acc_done), 32'd1);
        for (int i = 0; i < 8; i++) read_chk("t2_rd");

        // 3: N==1 forwarding over 15 passes
        start_run(1, 15);
        for (int i = 0; i < 15; i++) push(12'hFFF);
        wait_done("t3_done", 10);
        read_chk("t3_rd");
        chk("t3_const", 32'(bus.rd_data), 32'd61425);

        // 4: clamp to DEPTH
        start_run(2000, 1);
        for (int i = 0; i < 1024; i++) begin
            push(int'($urandom_range(0, 4095)));
            if (i == 1022) chk("t4_not_done_1023", 32'(bus.acc_done), 32'd0);
        end
        chk("t4_flush", 32'(bus.acc_done), 32'd0);
        tick();
        chk("t4_done", 32'(bus.acc_done), 32'd1);
        for (int i = 0; i < 1025; i++) read_chk("t4_rd");

        // 5: abort mid-run, fresh record with no residue
        start_run(6, 1);
        push(9);
        push(9);
        push(9);
        start_run(2, 2);
        push(5);
        push(5);
        push(7);
        push(7);
        wait_done("t5_done", 10);
        read_chk("t5_rd");
        read_chk("t5_rd");

        // acqnum=0: DONE next cycle, previous record untouched, strobes in DONE ignored
        start_run(0, 3);
        chk("t0_done", 32'(bus.acc_done), 32'd1);
        chk("t0_busy", 32'(bus.busy), 32'd0);
        push(123);
        read_chk("t0_rd");
        read_chk("t0_rd");

        // randomized runs with gaps
        for (int r = 0; r < 6; r++) begin
            start_run(int'($urandom_range(1, 12)), int'($urandom_range(0, 15)));
            while (mdl_active) begin
                push(int'($urandom_range(0, 4095)));
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_done("rnd_done", 10);
            for (int i = 0; i <= mdl_n; i++) read_chk("rnd_rd");
        end

        // 6: asynchronous reset mid-ACQ
        start_run(6, 1);
        push(3);
        push(4);
        s_reset = 1'b0;
        #1;
        chk("t6_rd_data", 32'(bus.rd_data), 32'd0);
        chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.acc_done), 32'd0);
        mdl_active = 1'b0;
        tick();
        s_reset = 1'b1;
        tick();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("t6_rd_ignored", 32'(bus.rd_valid), 32'd0);
        chk("t6_rd_data_held", 32'(bus.rd_data), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
